// File: rtl/alu_exec.sv
//------------------------------------------------------------------------------
// Module   : alu_exec
// Purpose  : Single-step 4-bit accumulator machine driven by a pushbutton.
//            EXEC is synchronized (and optionally debounced) into PRESS.
//            Each press latches INST into IR and then executes it once.
//            Results are written to ACC, INDEX, C and Z, and DONE pulses.
// Ports    : CLK   - system clock (rising edge)
//            RST   - synchronous active-high reset
//            EXEC  - asynchronous step pushbutton, active-high
//            INST  - instruction switches, [7:4] opcode, [3:0] immediate
//            IR    - instruction latched at the last execution
//            ACC   - accumulator
//            INDEX - index register
//            C, Z  - carry/borrow and zero flags
//            BUSY  - high whenever the FSM is not in IDLE
//            DONE  - one-cycle pulse in the cycle after results are written
// Options  : define ALU_EXEC_DEBOUNCE_EN to insert a DEB_CYCLES debounce
//            filter after the synchronizer
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module alu_exec #(
    parameter int DEB_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EXEC,
    input  logic [7:0] INST,
    output logic [7:0] IR,
    output logic [3:0] ACC,
    output logic [3:0] INDEX,
    output logic       C,
    output logic       Z,
    output logic       BUSY,
    output logic       DONE
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_HOLD = 2'd2;

    if (DEB_CYCLES < 1) begin : g_deb_check
        $error("DEB_CYCLES must be at least 1");
    end

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_sync1;
    logic       r_sync2;
    logic       w_press;
    logic       r_rst_q;
    logic [7:0] r_ir;
    logic [3:0] r_acc;
    logic [3:0] r_idx;
    logic       r_c;
    logic       r_z;
    logic       r_done;

    logic [3:0] w_op;
    logic [3:0] w_imm;
    logic [4:0] w_wide;
    logic [3:0] w_acc_nxt;
    logic [3:0] w_idx_nxt;
    logic       w_c_nxt;
    logic       w_z_nxt;
    logic       w_writes_acc;

    // Two-flop synchronizer for the asynchronous pushbutton.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= EXEC;
            r_sync2 <= r_sync1;
        end
    end

`ifdef ALU_EXEC_DEBOUNCE_EN
    localparam int                 c_CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEB_CYCLES - 1);

    logic [c_CNT_W-1:0] r_deb_cnt;
    logic               r_press;

    // PRESS follows the synchronized level only after DEB_CYCLES consecutive
    // samples disagree with it; any agreeing sample restarts the count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_deb_cnt <= '0;
            r_press   <= 1'b0;
        end else if (r_sync2 == r_press) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == c_CNT_LAST) begin
            r_deb_cnt <= '0;
            r_press   <= r_sync2;
        end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end

    assign w_press = r_press;
`else
    assign w_press = r_sync2;
`endif

    // Next-state logic. Leaving HOLD needs the button to be seen released
    // through the whole pipeline: reset wipes the synchronizer, so right
    // after reset PRESS reads low even if EXEC is still held. Waiting one
    // cycle past reset and for the first sync flop to read low prevents a
    // held button from triggering a phantom execution.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_press) w_state_nxt = c_ST_RUN;
            c_ST_RUN:  w_state_nxt = c_ST_HOLD;
            c_ST_HOLD: if (!w_press && !r_sync1 && !r_rst_q) w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_HOLD;
        endcase
    end

    // Datapath: results computed from IR only, 5 bits wide for carry.
    assign w_op  = r_ir[7:4];
    assign w_imm = r_ir[3:0];

    always_comb begin
        w_acc_nxt = r_acc;
        w_idx_nxt = r_idx;
        w_c_nxt   = r_c;
        w_z_nxt   = r_z;
        w_wide    = 5'd0;
        case (w_op)
            4'h0: ; // NOP
            4'h1: w_acc_nxt = w_imm;
            4'h2: begin
                w_wide    = {1'b0, r_acc} + {1'b0, w_imm};
                w_acc_nxt = w_wide[3:0];
                w_c_nxt   = w_wide[4];
            end
            4'h3: begin
                // Bit 4 of the 5-bit difference is the borrow (IMM > ACC).
                w_wide    = {1'b0, r_acc} - {1'b0, w_imm};
                w_acc_nxt = w_wide[3:0];
                w_c_nxt   = w_wide[4];
            end
            4'h4: w_acc_nxt = r_acc & w_imm;
            4'h5: w_acc_nxt = r_acc | w_imm;
            4'h6: w_acc_nxt = r_acc ^ w_imm;
            4'h7: w_acc_nxt = ~r_acc;
            4'h8: begin
                w_acc_nxt = {r_acc[2:0], 1'b0};
                w_c_nxt   = r_acc[3];
            end
            4'h9: begin
                w_acc_nxt = {1'b0, r_acc[3:1]};
                w_c_nxt   = r_acc[0];
            end
            4'hA: begin
                w_wide    = {1'b0, r_acc} + {1'b0, w_imm} + {4'd0, r_c};
                w_acc_nxt = w_wide[3:0];
                w_c_nxt   = w_wide[4];
            end
            4'hB: w_idx_nxt = w_imm;
            4'hC: begin
                w_wide    = {1'b0, r_acc} + {1'b0, r_idx};
                w_acc_nxt = w_wide[3:0];
                w_c_nxt   = w_wide[4];
            end
            4'hD: w_idx_nxt = r_acc;
            4'hE: w_idx_nxt = r_idx + 4'd1;
            4'hF: begin
                w_acc_nxt = 4'd0;
                w_idx_nxt = 4'd0;
                w_c_nxt   = 1'b0;
            end
            default: ;
        endcase
        // CLR is included: its ACC is zero, so Z comes out as 1.
        if (w_writes_acc) w_z_nxt = (w_acc_nxt == 4'd0);
    end

    assign w_writes_acc = ((w_op >= 4'h1) && (w_op <= 4'hA)) ||
                          (w_op == 4'hC) || (w_op == 4'hF);

    // State, instruction and architectural registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_ST_HOLD;
            r_rst_q <= 1'b1;
            r_ir    <= 8'd0;
            r_acc   <= 4'd0;
            r_idx   <= 4'd0;
            r_c     <= 1'b0;
            r_z     <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rst_q <= 1'b0;
            r_done  <= (r_state == c_ST_RUN);
            if ((r_state == c_ST_IDLE) && w_press) r_ir <= INST;
            if (r_state == c_ST_RUN) begin
                r_acc <= w_acc_nxt;
                r_idx <= w_idx_nxt;
                r_c   <= w_c_nxt;
                r_z   <= w_z_nxt;
            end
        end
    end

    assign IR    = r_ir;
    assign ACC   = r_acc;
    assign INDEX = r_idx;
    assign C     = r_c;
    assign Z     = r_z;
    assign BUSY  = (r_state != c_ST_IDLE);
    assign DONE  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_exec
// Purpose  : Self-checking bench for alu_exec. Each press pushes the expected
//            register state into a queue; the entry is popped and compared
//            when DONE is observed.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_alu_exec;

    localparam int DEB = 16;
`ifdef ALU_EXEC_DEBOUNCE_EN
    localparam int XLAT = DEB;
`else
    localparam int XLAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       exec;
    logic [7:0] inst;
    logic [7:0] ir;
    logic [3:0] acc;
    logic [3:0] index;
    logic       c;
    logic       z;
    logic       busy;
    logic       done;

    alu_exec #(.DEB_CYCLES(DEB)) dut (
        .CLK   (clk),
        .RST   (rst),
        .EXEC  (exec),
        .INST  (inst),
        .IR    (ir),
        .ACC   (acc),
        .INDEX (index),
        .C     (c),
        .Z     (z),
        .BUSY  (busy),
        .DONE  (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] ir;
        logic [3:0] acc;
        logic [3:0] idx;
        logic       c;
        logic       z;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] m_acc;
    logic [3:0] m_idx;
    logic       m_c;
    logic       m_z;
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference behaviour written with plain integer arithmetic.
    task automatic model(input logic [7:0] ins);
        int imm;
        int a;
        int t;
        imm = int'(ins[3:0]);
        a   = int'(m_acc);
        case (ins[7:4])
            4'h1: a = imm;
            4'h2: begin t = a + imm; m_c = (t > 15); a = t % 16; end
            4'h3: begin m_c = (imm > a); a = (a - imm + 16) % 16; end
            4'h4: a = a & imm;
            4'h5: a = a | imm;
            4'h6: a = a ^ imm;
            4'h7: a = 15 - a;
            4'h8: begin m_c = (a >= 8); a = (a * 2) % 16; end
            4'h9: begin m_c = (a % 2 == 1); a = a / 2; end
            4'hA: begin t = a + imm + (m_c ? 1 : 0); m_c = (t > 15); a = t % 16; end
            4'hB: m_idx = ins[3:0];
            4'hC: begin t = a + int'(m_idx); m_c = (t > 15); a = t % 16; end
            4'hD: m_idx = m_acc;
            4'hE: m_idx = (m_idx == 4'hF) ? 4'h0 : m_idx + 4'd1;
            4'hF: begin a = 0; m_idx = 4'd0; m_c = 1'b0; end
            default: ;
        endcase
        m_acc = a[3:0];
        if (!(ins[7:4] == 4'h0 || ins[7:4] == 4'hB || ins[7:4] == 4'hD || ins[7:4] == 4'hE))
            m_z = (a == 0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 80 + 2 * XLAT) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic reset_model();
        m_acc = 4'd0; m_idx = 4'd0; m_c = 1'b0; m_z = 1'b0;
    endtask

    // One press held for 'hold' cycles; INST is scrambled after it is latched.
    task automatic do_exec(input logic [7:0] ins, input int hold, input string tag);
        int   done_cnt;
        int   done_edge;
        exp_t e;
        inst = ins;
        model(ins);
        sb.push_back({ins, m_acc, m_idx, m_c, m_z});
        @(negedge clk);
        exec = 1'b1;
        done_cnt  = 0;
        done_edge = -1;
        for (int i = 1; i <= hold; i++) begin
            @(posedge clk); #1;
            if (i == 3 + XLAT) inst = ~ins;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_edge < 0) begin
                    done_edge = i;
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk({tag, "_ir"},  {24'd0, ir},    {24'd0, e.ir});
                        chk({tag, "_acc"}, {28'd0, acc},   {28'd0, e.acc});
                        chk({tag, "_idx"}, {28'd0, index}, {28'd0, e.idx});
                        chk({tag, "_c"},   {31'd0, c},     {31'd0, e.c});
                        chk({tag, "_z"},   {31'd0, z},     {31'd0, e.z});
                    end
                end
            end
        end
        @(negedge clk);
        exec = 1'b0;
        chk({tag, "_done_cnt"},  done_cnt,  1);
        chk({tag, "_done_edge"}, done_edge, 4 + XLAT);
        chk({tag, "_sb_drain"},  sb.size(), 0);
        sb.delete();
        wait_idle(tag);
    endtask

    logic [7:0] extra[12] = '{8'hF0, 8'h1A, 8'h80, 8'h6F, 8'h70, 8'h4C,
                              8'h53, 8'hB3, 8'hC0, 8'hD0, 8'h00, 8'hE0};

    initial begin
        int cnt;
        rst  = 1'b1;
        exec = 1'b0;
        inst = 8'h00;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ir",    {24'd0, ir},    32'd0);
        chk("rst_acc",   {28'd0, acc},   32'd0);
        chk("rst_index", {28'd0, index}, 32'd0);
        chk("rst_c",     {31'd0, c},     32'd0);
        chk("rst_z",     {31'd0, z},     32'd0);
        chk("rst_done",  {31'd0, done},  32'd0);
        chk("rst_busy",  {31'd0, busy},  32'd1);
        @(negedge clk);
        rst = 1'b0;
        wait_idle("post_rst");

        do_exec(8'h17, 8 + XLAT, "ldi7");

        do_exec(8'h1F, 8 + XLAT, "ldiF");
        do_exec(8'h21, 8 + XLAT, "add1");
        do_exec(8'hA2, 8 + XLAT, "adc2");

        do_exec(8'h12, 8 + XLAT, "ldi2");
        do_exec(8'h35, 8 + XLAT, "sub5");
        do_exec(8'h90, 8 + XLAT, "shr");

        do_exec(8'hBF, 8 + XLAT, "ldxF");
        do_exec(8'hE0, 50,       "incx_hold50");

        foreach (extra[k]) do_exec(extra[k], 8 + XLAT, $sformatf("op%02h", extra[k]));

        // Reset landing in the RUN cycle, with EXEC held through it.
        do_exec(8'h15, 8 + XLAT, "ldi5");
        inst = 8'h19;
        @(negedge clk);
        exec = 1'b1;
        repeat (3 + XLAT) @(posedge clk);
        #1;
        chk("run_ir", {24'd0, ir}, 32'h19);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_acc",  {28'd0, acc},  32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        cnt = 0;
        for (int i = 0; i < 30 + XLAT; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) cnt++;
        end
        chk("held_no_done", cnt, 0);
        chk("held_acc", {28'd0, acc}, 32'd0);
        chk("held_ir",  {24'd0, ir},  32'd0);
        @(negedge clk);
        exec = 1'b0;
        wait_idle("release");
        do_exec(8'h13, 8 + XLAT, "repress");

`ifdef ALU_EXEC_DEBOUNCE_EN
        // A 10-cycle glitch is too short to qualify as a press.
        inst = 8'h1E;
        @(negedge clk);
        exec = 1'b1;
        repeat (10) @(negedge clk);
        exec = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) cnt++;
        end
        chk("deb_short_done", cnt, 0);
        chk("deb_short_acc", {28'd0, acc}, {28'd0, m_acc});
        do_exec(8'h1E, 20, "deb20");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 16, meaning the consecutive high samples that qualify a press when debounce is compiled in.
REQ-002 The block SHALL have port CLK  input  1  system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port EXEC  input  1  asynchronous step pushbutton, active-high.
REQ-005 The block SHALL have port INST  input  8  instruction switches: [7:4] opcode, [3:0] immediate IMM.
REQ-006 The block SHALL have port IR  output  8  instruction latched at the last execution; feeds the display selector INST input.
REQ-007 The block SHALL have port ACC  output  4  accumulator register.
REQ-008 The block SHALL have port INDEX  output  4  index register.
REQ-009 The block SHALL have ports C and Z  output  1 each  carry/borrow flag and zero flag, active-high.
REQ-010 The block SHALL have port BUSY  output  1  high when not in IDLE.
REQ-011 The block SHALL have port DONE  output  1  one-cycle pulse, high in the cycle after results are written.

Function
REQ-012 EXEC SHALL pass through a 2-flop synchronizer; its second flop is PRESS (without debounce).
REQ-013 The FSM SHALL have states IDLE, RUN and HOLD: IDLE->RUN when PRESS=1, latching INST into IR on that edge; RUN->HOLD unconditionally, writing results on that edge; HOLD->IDLE when PRESS=0.
REQ-014 Results SHALL appear on ACC/INDEX/C/Z at the 4th rising edge after EXEC is first sampled high, and DONE SHALL be high for exactly the following cycle.
REQ-015 Holding EXEC high SHALL execute exactly one instruction; the next execution requires PRESS to return low.
REQ-016 Opcodes SHALL be: 0 NOP; 1 LDI ACC=IMM; 2 ADD ACC=ACC+IMM; 3 SUB ACC=ACC-IMM; 4 AND; 5 OR; 6 XOR (all with IMM); 7 NOT ACC=~ACC.
REQ-017 Opcodes SHALL further be: 8 SHL; 9 SHR (logical); A ADC ACC=ACC+IMM+C; B LDX INDEX=IMM; C ADDX ACC=ACC+INDEX; D MOVX INDEX=ACC; E INCX INDEX=INDEX+1; F CLR.
REQ-018 Arithmetic SHALL be computed 5 bits wide; ADD/ADC/ADDX set C to bit 4; SUB sets C=1 on borrow (IMM>ACC); SHL sets C=old ACC[3]; SHR sets C=old ACC[0].
REQ-019 AND/OR/XOR/NOT/LDI SHALL leave C unchanged.
REQ-020 Every opcode writing ACC (1-A, C) SHALL set Z=(new ACC==0); opcodes 0, B, D, E SHALL leave C and Z unchanged.
REQ-021 INCX SHALL wrap 4'hF to 4'h0 with no flag change.
REQ-022 CLR SHALL set ACC=0, INDEX=0, C=0 and Z=1.
REQ-023 INST changes outside the IDLE->RUN edge SHALL have no effect; the execution uses IR only.

Reset
REQ-024 While RST=1 at a rising edge, the block SHALL set IR=0, ACC=0, INDEX=0, C=0, Z=0, DONE=0, clear the synchronizer, debounce counter and PRESS, and load state HOLD, with BUSY=1.
REQ-025 Reset during RUN SHALL abort the instruction with no register write, and no DONE pulse SHALL follow.
REQ-026 After reset with EXEC still held, no instruction SHALL execute until PRESS has been seen low.

Configuration
REQ-027 With macro ALU_EXEC_DEBOUNCE_EN defined, PRESS SHALL rise only after the synchronized EXEC is high for DEB_CYCLES consecutive cycles, and SHALL fall after DEB_CYCLES consecutive low cycles; any opposite sample SHALL restart the count, and REQ-014 latency SHALL increase by DEB_CYCLES.
REQ-028 Without ALU_EXEC_DEBOUNCE_EN, PRESS SHALL equal the synchronizer output, the counter SHALL be absent, and DEB_CYCLES SHALL be ignored.

Verification
REQ-029 The bench SHALL cover: reset; EXEC released; INST=8'h17 pressed -> ACC=7, Z=0, C=0, IR=8'h17, DONE one cycle at the 4th edge plus one.
REQ-030 The bench SHALL cover: ACC=F, then ADD 1 (8'h21) -> ACC=0, C=1, Z=1; then ADC 2 (8'hA2) -> ACC=3, C=0, Z=0.
REQ-031 The bench SHALL cover: ACC=2, then SUB 5 (8'h35) -> ACC=D, C=1, Z=0; then SHR (8'h90) -> ACC=6, C=1.
REQ-032 The bench SHALL cover: LDX F (8'hBF), then INCX (8'hE0) -> INDEX=0 with C/Z unchanged; EXEC held 50 cycles -> exactly one DONE.
REQ-033 The bench SHALL cover: RST asserted in the RUN cycle -> ACC=0, no DONE; EXEC held through reset -> no execution until release and re-press.
REQ-034 With ALU_EXEC_DEBOUNCE_EN and DEB_CYCLES=16, the bench SHALL check: a 10-cycle EXEC pulse -> no execution; a 20-cycle press -> one execution at edge 4+16.
